// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg
// Shared definitions for the general-purpose register file: default widths,
// architectural register indices, the commit record type and the helper that
// decides whether a W-stage write really changes state.
package gpr_file_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  // $zero is hardwired; $ra is the link register used by jal/jalr.
  localparam logic [GPR_ADDR_W-1:0] REG_ZERO = GPR_ADDR_W'(0);
  localparam logic [GPR_ADDR_W-1:0] REG_RA   = GPR_ADDR_W'(31);

  // One retired register write, as seen by a trace monitor.
  typedef struct packed {
    logic [31:0]           pc;
    logic [GPR_ADDR_W-1:0] addr;
    logic [GPR_DATA_W-1:0] data;
  } commit_rec_t;

  // A write only counts when enabled and not aimed at $zero.
  function automatic logic is_effective(input logic we,
                                        input logic [GPR_ADDR_W-1:0] a3);
    return we && (a3 != REG_ZERO);
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// gpr_file_if
// Bundles the W-stage write port, the two D-stage read ports and the commit
// log of the register file.
//   master : pipeline side, drives write/read requests, receives rd1/rd2/commit
//   slave  : register file side
interface gpr_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              we_w;
  logic [ADDR_W-1:0] a3_w;
  logic [DATA_W-1:0] wd_w;
  logic [31:0]       pc_w;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [31:0]       commit_count;

  modport master (
    output we_w, a3_w, wd_w, pc_w, a1, a2,
    input  rd1, rd2, commit_valid, commit_pc, commit_addr, commit_data,
           commit_count
  );

  modport slave (
    input  we_w, a3_w, wd_w, pc_w, a1, a2,
    output rd1, rd2, commit_valid, commit_pc, commit_addr, commit_data,
           commit_count
  );

endinterface

// File: rtl/gpr_file_read_port.sv
// gpr_read_port
// One asynchronous read port of the register file.
//   addr     : read index
//   wr_en    : effective write this cycle (already excludes index 0)
//   wr_addr  : index being written this cycle
//   wr_data  : data being written this cycle
//   mem_data : storage contents at addr
//   rdata    : $zero -> 0, same-cycle write -> wr_data, else mem_data
module gpr_read_port
  import gpr_file_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rdata
);

  // The W->D bypass lives here so the hazard unit never forwards from W.
  always_comb begin
    rdata = mem_data;
    if (addr == ADDR_W'(0)) begin
      rdata = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      rdata = wr_data;
    end
  end

endmodule

// File: rtl/gpr_file.sv
// gpr_file
// 32 x 32-bit MIPS general-purpose register file with one W-stage write port,
// two combinational D-stage read ports with internal write-through bypass,
// a registered commit record and a retired-write counter.
//   clk   : clock
//   reset : synchronous, active-high; clears storage, commit record, counter
//   bus   : gpr_file_if slave (write port, read ports, commit log)
// The commit record type comes from the package, so DATA_W/ADDR_W are
// expected to match the package defaults.
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W
) (
  input logic        clk,
  input logic        reset,
  gpr_file_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_eff;
  logic              commit_valid_q;
  commit_rec_t       commit_q;
  logic [31:0]       count_q;
  logic [DATA_W-1:0] rd1_int;
  logic [DATA_W-1:0] rd2_int;

  assign wr_eff = is_effective(bus.we_w, bus.a3_w);

  // Storage. Entry 0 is cleared by reset and never written, and the read
  // ports mask it anyway. Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[bus.a3_w] <= bus.wd_w;
    end
  end

  // Commit record: valid pulses for one cycle after each effective write;
  // the payload fields hold their last value otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
    end else begin
      commit_valid_q <= wr_eff;
      if (wr_eff) begin
        commit_q.pc   <= bus.pc_w;
        commit_q.addr <= bus.a3_w;
        commit_q.data <= bus.wd_w;
      end
    end
  end

  // Retired-write counter, wraps naturally at 2**32.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (wr_eff) begin
      count_q <= count_q + 32'd1;
    end
  end

  gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr     (bus.a1),
    .wr_en    (wr_eff),
    .wr_addr  (bus.a3_w),
    .wr_data  (bus.wd_w),
    .mem_data (regs[bus.a1]),
    .rdata    (rd1_int)
  );

  gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr     (bus.a2),
    .wr_en    (wr_eff),
    .wr_addr  (bus.a3_w),
    .wr_data  (bus.wd_w),
    .mem_data (regs[bus.a2]),
    .rdata    (rd2_int)
  );

  assign bus.rd1          = rd1_int;
  assign bus.rd2          = rd2_int;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_pc    = commit_q.pc;
  assign bus.commit_addr  = commit_q.addr;
  assign bus.commit_data  = commit_q.data;
  assign bus.commit_count = count_q;

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file
// Self-checking bench for gpr_file: directed scenarios plus a randomized
// stream compared against an array-based model of the register file.
module tb_gpr_file;
  import gpr_file_pkg::*;

  logic clk;
  logic reset;

  gpr_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  gpr_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Reference model: architectural register contents and the last commit.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_count;

  // Value a D-stage read of idx must return given the current W-stage inputs.
  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.we_w && bus.a3_w == idx) return bus.wd_w;
    return m_regs[idx];
  endfunction

  // Advance one clock edge and update the model with what that edge retires.
  task automatic clock_cycle();
    logic eff;
    eff = bus.we_w && (bus.a3_w != 5'd0);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_pc = 32'd0; m_addr = 5'd0; m_data = 32'd0;
      m_count = 32'd0;
    end else begin
      m_valid = eff;
      if (eff) begin
        m_regs[bus.a3_w] = bus.wd_w;
        m_pc   = bus.pc_w;
        m_addr = bus.a3_w;
        m_data = bus.wd_w;
        m_count = m_count + 32'd1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.we_w = 1'b0; bus.a3_w = 5'd0; bus.wd_w = 32'd0; bus.pc_w = 32'd0;
    bus.a1 = 5'd0; bus.a2 = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    clock_cycle();
    clock_cycle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.a1 = 5'(i);
      bus.a2 = 5'(31 - i);
      #1;
      assertions++;
      if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_read idx=%0d rd1=%h rd2=%h expected 0", i, bus.rd1, bus.rd2);
      end
    end
    assertions++;
    if (bus.commit_valid !== 1'b0 || bus.commit_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_commit valid=%b count=%h expected 0/0", bus.commit_valid, bus.commit_count);
    end
    assertions++;
    if (bus.commit_pc !== 32'd0 || bus.commit_addr !== 5'd0 || bus.commit_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_fields pc=%h addr=%0d data=%h expected zeros", bus.commit_pc, bus.commit_addr, bus.commit_data);
    end
  endtask

  task automatic test_write_bypass();
    bus.we_w = 1'b1; bus.a3_w = 5'd8; bus.wd_w = 32'h1234_5678; bus.pc_w = 32'h3000;
    bus.a1 = 5'd8; bus.a2 = 5'd0;
    #1;
    assertions++;
    if (bus.rd1 !== 32'h1234_5678 || bus.rd2 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL bypass rd1=%h rd2=%h expected 12345678/0", bus.rd1, bus.rd2);
    end
    clock_cycle();
    bus.we_w = 1'b0;
    #1;
    assertions++;
    if (bus.commit_valid !== 1'b1 || bus.commit_pc !== 32'h3000 || bus.commit_addr !== 5'd8 ||
        bus.commit_data !== 32'h1234_5678 || bus.commit_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL first_commit valid=%b pc=%h addr=%0d data=%h count=%0d expected 1/3000/8/12345678/1",
               bus.commit_valid, bus.commit_pc, bus.commit_addr, bus.commit_data, bus.commit_count);
    end
    clock_cycle();
    assertions++;
    if (bus.commit_valid !== 1'b0 || bus.rd1 !== 32'h1234_5678 || bus.commit_pc !== 32'h3000) begin
      failures++;
      $display("[TB] FAIL after_commit valid=%b rd1=%h pc=%h expected 0/12345678/3000",
               bus.commit_valid, bus.rd1, bus.commit_pc);
    end
  endtask

  task automatic test_zero_write();
    logic [31:0] start_count;
    start_count = m_count;
    bus.we_w = 1'b1; bus.a3_w = 5'd0; bus.wd_w = 32'hFFFF_FFFF; bus.pc_w = 32'h3004;
    bus.a1 = 5'd0; bus.a2 = 5'd0;
    #1;
    assertions++;
    if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL zero_read rd1=%h rd2=%h expected 0", bus.rd1, bus.rd2);
    end
    clock_cycle();
    bus.we_w = 1'b0;
    #1;
    assertions++;
    if (bus.commit_valid !== 1'b0 || bus.commit_count !== start_count || bus.commit_pc !== 32'h3000) begin
      failures++;
      $display("[TB] FAIL zero_commit valid=%b count=%0d pc=%h expected 0/%0d/3000",
               bus.commit_valid, bus.commit_count, bus.commit_pc, start_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] start_count;
    start_count = m_count;
    bus.we_w = 1'b1; bus.a3_w = 5'd5; bus.wd_w = 32'd1; bus.pc_w = 32'h4000;
    bus.a1 = 5'd5; bus.a2 = 5'd5;
    #1;
    assertions++;
    if (bus.rd1 !== 32'd1 || bus.rd2 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL b2b_cycle1 rd1=%h rd2=%h expected 1/1", bus.rd1, bus.rd2);
    end
    clock_cycle();
    bus.wd_w = 32'd2; bus.pc_w = 32'h4004;
    #1;
    assertions++;
    if (bus.rd1 !== 32'd2 || bus.rd2 !== 32'd2 || bus.commit_valid !== 1'b1 || bus.commit_data !== 32'd1) begin
      failures++;
      $display("[TB] FAIL b2b_cycle2 rd1=%h rd2=%h valid=%b data=%h expected 2/2/1/1",
               bus.rd1, bus.rd2, bus.commit_valid, bus.commit_data);
    end
    clock_cycle();
    bus.we_w = 1'b0;
    #1;
    assertions++;
    if (bus.commit_valid !== 1'b1 || bus.commit_data !== 32'd2 || bus.commit_pc !== 32'h4004 ||
        bus.commit_count !== start_count + 32'd2 || bus.rd1 !== 32'd2) begin
      failures++;
      $display("[TB] FAIL b2b_final valid=%b data=%h pc=%h count=%0d rd1=%h expected 1/2/4004/%0d/2",
               bus.commit_valid, bus.commit_data, bus.commit_pc, bus.commit_count, bus.rd1, start_count + 32'd2);
    end
    clock_cycle();
  endtask

  task automatic test_reset_mid_stream();
    bus.we_w = 1'b1; bus.a3_w = REG_RA; bus.wd_w = 32'hABCD; bus.pc_w = 32'h5000;
    clock_cycle();
    reset = 1'b1; bus.wd_w = 32'h1; bus.pc_w = 32'h5004;
    clock_cycle();
    reset = 1'b0; bus.we_w = 1'b0; bus.a1 = REG_RA; bus.a2 = 5'd31;
    #1;
    assertions++;
    if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0 || bus.commit_valid !== 1'b0 ||
        bus.commit_count !== 32'd0 || bus.commit_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid rd1=%h rd2=%h valid=%b count=%0d data=%h expected all 0",
               bus.rd1, bus.rd2, bus.commit_valid, bus.commit_count, bus.commit_data);
    end
    clock_cycle();
    assertions++;
    if (bus.commit_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_late valid=%b expected 0", bus.commit_valid);
    end
  endtask

  task automatic test_count_wrap();
    dut.count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    bus.we_w = 1'b1; bus.a3_w = 5'd3; bus.wd_w = 32'hCAFE_0003; bus.pc_w = 32'h6000;
    clock_cycle();
    bus.we_w = 1'b0;
    #1;
    assertions++;
    if (bus.commit_count !== 32'd0 || bus.commit_valid !== 1'b1 || bus.commit_addr !== 5'd3) begin
      failures++;
      $display("[TB] FAIL count_wrap count=%h valid=%b addr=%0d expected 0/1/3",
               bus.commit_count, bus.commit_valid, bus.commit_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      bus.we_w  = ($urandom_range(0, 3) != 0);
      bus.a3_w  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.wd_w  = $urandom;
      bus.pc_w  = $urandom & 32'hFFFF_FFFC;
      bus.a1    = ($urandom_range(0, 2) == 0) ? bus.a3_w : 5'($urandom_range(0, 31));
      bus.a2    = ($urandom_range(0, 2) == 0) ? bus.a3_w : 5'($urandom_range(0, 31));
      #1;
      e1 = model_read(bus.a1);
      e2 = model_read(bus.a2);
      assertions++;
      if (bus.rd1 !== e1 || bus.rd2 !== e2) begin
        failures++;
        $display("[TB] FAIL rand_read n=%0d a1=%0d rd1=%h exp %h a2=%0d rd2=%h exp %h",
                 n, bus.a1, bus.rd1, e1, bus.a2, bus.rd2, e2);
      end
      clock_cycle();
      assertions++;
      if (bus.commit_valid !== m_valid || bus.commit_pc !== m_pc || bus.commit_addr !== m_addr ||
          bus.commit_data !== m_data || bus.commit_count !== m_count) begin
        failures++;
        $display("[TB] FAIL rand_commit n=%0d got %b/%h/%0d/%h/%0d expected %b/%h/%0d/%h/%0d", n,
                 bus.commit_valid, bus.commit_pc, bus.commit_addr, bus.commit_data, bus.commit_count,
                 m_valid, m_pc, m_addr, m_data, m_count);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_pc = 32'd0; m_addr = 5'd0; m_data = 32'd0; m_count = 32'd0;
    #2;
    test_reset();
    test_write_bypass();
    test_zero_write();
    test_back_to_back();
    test_reset_mid_stream();
    test_count_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
